// File: rtl/monitor_pkg.sv
// Shared constants for the pin-monitor capture path and SPI frame shifter.
// Record layout: pins in the upper bits, timestamp in the lower bits.
package monitor_pkg;

    localparam int PIN_WIDTH_DEF  = 8;
    localparam int TIME_WIDTH_DEF = 32;
    localparam int REC_WIDTH      = PIN_WIDTH_DEF + TIME_WIDTH_DEF;

    localparam int REC_PIN_MSB  = REC_WIDTH - 1;
    localparam int REC_PIN_LSB  = TIME_WIDTH_DEF;
    localparam int REC_TIME_MSB = TIME_WIDTH_DEF - 1;
    localparam int REC_TIME_LSB = 0;

    typedef enum logic [1:0] {
        LOAD_NONE,
        LOAD_FIFO,
        LOAD_BYPASS,
        LOAD_IDLE
    } load_sel_e;

endpackage

// File: rtl/record_fifo.sv
// Single-clock record FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module record_fifo
    import monitor_pkg::*;
#(
    parameter int WIDTH = REC_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop) level_d = level_q + LW'(1);
        if (!do_push && do_pop) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; the level counter gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/capture_scheduler.sv
// Timestamps pin changes, buffers them and hands one record per SPI frame
// request to the shifter; an idle snapshot is served when nothing is queued.
module capture_scheduler
    import monitor_pkg::*;
#(
    parameter int PIN_WIDTH  = PIN_WIDTH_DEF,
    parameter int TIME_WIDTH = TIME_WIDTH_DEF,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PIN_WIDTH-1:0]    pin_values,
    input  logic                    record_req,
    output logic                    record_valid,
    output logic [PIN_WIDTH-1:0]    record_pins,
    output logic [TIME_WIDTH-1:0]   record_time,
    output logic                    record_is_change,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    overflow,
    input  logic                    clear_overflow,
    output logic [TIME_WIDTH-1:0]   time_now
);

    localparam int RW = PIN_WIDTH + TIME_WIDTH;

    logic [TIME_WIDTH-1:0] time_q;
    logic [PIN_WIDTH-1:0]  samp_q, last_q;
    logic [PIN_WIDTH-1:0]  pins_q, pins_d;
    logic [TIME_WIDTH-1:0] rtime_q, rtime_d;
    logic                  is_chg_q, is_chg_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;

    logic                  change;
    logic                  fifo_full, fifo_empty;
    logic                  push, pop, drop;
    logic [RW-1:0]         head, cur_rec;
    load_sel_e             sel;

    assign change  = (samp_q != last_q);
    assign cur_rec = {samp_q, time_q};

    always_comb begin
        sel = LOAD_NONE;
        if (record_req) begin
            if (!fifo_empty) sel = LOAD_FIFO;
            else if (change) sel = LOAD_BYPASS;
            else             sel = LOAD_IDLE;
        end
    end

    // A bypassed change goes straight to the outputs, never into the FIFO.
    assign pop  = (sel == LOAD_FIFO);
    assign push = change && (sel != LOAD_BYPASS);
    assign drop = push && fifo_full && !pop;

    record_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (cur_rec),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        pins_d   = pins_q;
        rtime_d  = rtime_q;
        is_chg_d = is_chg_q;
        valid_d  = valid_q;
        unique case (sel)
            LOAD_FIFO: begin
                pins_d   = head[RW-1:TIME_WIDTH];
                rtime_d  = head[TIME_WIDTH-1:0];
                is_chg_d = 1'b1;
                valid_d  = 1'b1;
            end
            LOAD_BYPASS, LOAD_IDLE: begin
                pins_d   = samp_q;
                rtime_d  = time_q;
                is_chg_d = (sel == LOAD_BYPASS);
                valid_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // Setting wins over a same-cycle clear so no drop goes unreported.
    always_comb begin
        ovf_d = ovf_q;
        if (drop)                ovf_d = 1'b1;
        else if (clear_overflow) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_q   <= '0;
            samp_q   <= '0;
            last_q   <= '0;
            pins_q   <= '0;
            rtime_q  <= '0;
            is_chg_q <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            time_q   <= time_q + TIME_WIDTH'(1);
            samp_q   <= pin_values;
            last_q   <= samp_q;
            pins_q   <= pins_d;
            rtime_q  <= rtime_d;
            is_chg_q <= is_chg_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign record_valid     = valid_q;
    assign record_pins      = pins_q;
    assign record_time      = rtime_q;
    assign record_is_change = is_chg_q;
    assign overflow         = ovf_q;
    assign time_now         = time_q;

endmodule
